// File: rtl/bit_index_decoder.sv
// rtl/bit_index_decoder.sv - two-stage valid/ready decoder from 5-bit bit index to one-hot or bit mask
//
// Purpose:
//   Inverse of the leading-one priority encoder. Expands a bit index into a
//   one-hot word, an "at or below" mask, or an "above" mask. Two register
//   stages with full backpressure; holds at most two items.
//
// Ports:
//   i_clk         rising-edge clock
//   i_reset       synchronous active-high reset
//   i_in_valid    request present
//   o_in_ready    request accepted this cycle (0 during reset)
//   i_in_index    bit position 0..WIDTH-1
//   i_in_mode     0 ONEHOT, 1 MASK_LE, 2 MASK_GT, 3 reserved
//   i_in_zero     encoder "no bit set" flag, forces a zero result
//   o_out_valid   result present
//   i_out_ready   consumer accepts result
//   o_out_data    decoded result
//   o_out_index   echo of the request index
//   o_out_err     request used reserved mode 3

module bit_index_decoder #(
  parameter int WIDTH = 32,
  localparam int IDXW = $clog2(WIDTH)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [IDXW-1:0]  i_in_index,
  input  logic [1:0]       i_in_mode,
  input  logic             i_in_zero,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_out_data,
  output logic [IDXW-1:0]  o_out_index,
  output logic             o_out_err
);

  localparam logic [1:0] MODE_ONEHOT  = 2'd0;
  localparam logic [1:0] MODE_MASK_LE = 2'd1;
  localparam logic [1:0] MODE_MASK_GT = 2'd2;

  // Stage 1 registers
  logic             r_s1_valid;
  logic [WIDTH-1:0] r_s1_onehot;
  logic [1:0]       r_s1_mode;
  logic             r_s1_zero;
  logic [IDXW-1:0]  r_s1_index;

  // Stage 2 (output) registers
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic [IDXW-1:0]  r_out_index;
  logic             r_out_err;

  logic             w_s2_adv;
  logic             w_s1_adv;
  logic [WIDTH-1:0] w_mask_le;
  logic [WIDTH-1:0] w_result;
  logic             w_err;

  // Output stage moves when empty or drained; stage 1 moves when empty or
  // when it can push into stage 2. i_out_ready only reaches o_in_ready.
  assign w_s2_adv   = !r_out_valid || i_out_ready;
  assign w_s1_adv   = !r_s1_valid || w_s2_adv;
  assign o_in_ready = w_s1_adv && !i_reset;

  // onehot | (onehot - 1) sets bits idx..0. Because onehot is never zero this
  // equals (onehot << 1) - 1 taken WIDTH+1 bits wide, so idx = WIDTH-1 yields
  // all ones without needing the extra carry bit.
  assign w_mask_le = r_s1_onehot | (r_s1_onehot - WIDTH'(1));

  always_comb begin
    w_result = '0;
    w_err    = 1'b0;
    case (r_s1_mode)
      MODE_ONEHOT:  w_result = r_s1_onehot;
      MODE_MASK_LE: w_result = w_mask_le;
      MODE_MASK_GT: w_result = ~w_mask_le;
      default: begin
        w_result = '0;
        w_err    = 1'b1;
      end
    endcase
    if (r_s1_zero) begin
      w_result = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_s1_valid  <= 1'b0;
      r_s1_onehot <= '0;
      r_s1_mode   <= '0;
      r_s1_zero   <= 1'b0;
      r_s1_index  <= '0;
    end else if (w_s1_adv) begin
      r_s1_valid <= i_in_valid;
      if (i_in_valid) begin
        r_s1_onehot <= WIDTH'(1) << i_in_index;
        r_s1_mode   <= i_in_mode;
        r_s1_zero   <= i_in_zero;
        r_s1_index  <= i_in_index;
      end
    end
  end

  // Payload only loads with a real item so an emptied output keeps its last
  // value instead of picking up stale stage-1 contents.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_index <= '0;
      r_out_err   <= 1'b0;
    end else if (w_s2_adv) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_data  <= w_result;
        r_out_index <= r_s1_index;
        r_out_err   <= w_err;
      end
    end
  end

  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_out_data;
  assign o_out_index = r_out_index;
  assign o_out_err   = r_out_err;

endmodule

// File: tb/tb_bit_index_decoder.sv
// tb/tb_bit_index_decoder.sv - self-checking bench for bit_index_decoder

module tb_bit_index_decoder;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_index;
  logic [1:0]  in_mode;
  logic        in_zero;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_index;
  logic        out_err;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [31:0] d;
    logic [4:0]  i;
    logic        e;
  } exp_t;

  exp_t q[$];

  int b_idx[8];
  int b_mode[8];
  bit b_zero[8];

  bit_index_decoder #(.WIDTH(32)) dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_in_index  (in_index),
    .i_in_mode   (in_mode),
    .i_in_zero   (in_zero),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_out_data  (out_data),
    .o_out_index (out_index),
    .o_out_err   (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_data(input int idx, input int mode, input bit zero);
    logic [63:0] le;
    logic [63:0] oh;
    oh = 64'd1 << idx;
    le = (64'd1 << (idx + 1)) - 64'd1;
    if (zero || mode == 3) return 32'd0;
    case (mode)
      0:       return oh[31:0];
      1:       return le[31:0];
      default: return ~le[31:0];
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Streams n items from b_* with out_ready held high; results expected
  // in the cycle two after each item is presented.
  task automatic run_burst(input string tag, input int n);
    for (int c = 0; c < n + 2; c++) begin
      if (c < n) begin
        in_valid = 1'b1;
        in_index = 5'(b_idx[c]);
        in_mode  = 2'(b_mode[c]);
        in_zero  = b_zero[c];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (c < n) check({tag, " in_ready"}, 64'(in_ready), 64'd1);
      if (c >= 2) begin
        check({tag, " out_valid"}, 64'(out_valid), 64'd1);
        check({tag, " out_data"}, 64'(out_data),
              64'(ref_data(b_idx[c-2], b_mode[c-2], b_zero[c-2])));
        check({tag, " out_index"}, 64'(out_index), 64'(b_idx[c-2]));
        check({tag, " out_err"}, 64'(out_err), 64'(b_mode[c-2] == 3));
      end
      next_cycle();
    end
    #1;
    check({tag, " drained"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    int   sent;
    int   recv;
    int   cyc;
    bit   pend;
    bit   prev_stall;
    exp_t prev_out;
    exp_t e;
    int   p_idx;
    int   p_mode;
    bit   p_zero;
    bit   in_fire;
    bit   out_fire;

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_index  = '0;
    in_mode   = '0;
    in_zero   = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    next_cycle();

    // Reset state
    #1;
    check("rst in_ready", 64'(in_ready), 64'd0);
    check("rst out_valid", 64'(out_valid), 64'd0);
    check("rst out_data", 64'(out_data), 64'd0);
    check("rst out_index", 64'(out_index), 64'd0);
    check("rst out_err", 64'(out_err), 64'd0);

    // 1: single item latency
    reset    = 1'b0;
    in_valid = 1'b1;
    in_index = 5'd5;
    in_mode  = 2'd0;
    #1;
    check("t1 in_ready", 64'(in_ready), 64'd1);
    next_cycle();
    in_valid = 1'b0;
    #1;
    check("t1 early out_valid", 64'(out_valid), 64'd0);
    next_cycle();
    #1;
    check("t1 out_valid", 64'(out_valid), 64'd1);
    check("t1 out_data", 64'(out_data), 64'h20);
    check("t1 out_index", 64'(out_index), 64'd5);
    check("t1 out_err", 64'(out_err), 64'd0);
    next_cycle();

    // 2: back-to-back stream
    b_idx[0] = 0;  b_mode[0] = 1; b_zero[0] = 0;
    b_idx[1] = 31; b_mode[1] = 1; b_zero[1] = 0;
    b_idx[2] = 7;  b_mode[2] = 2; b_zero[2] = 0;
    run_burst("t2", 3);

    // 3: boundaries
    b_idx[0] = 31; b_mode[0] = 2; b_zero[0] = 0;
    b_idx[1] = 0;  b_mode[1] = 1; b_zero[1] = 0;
    b_idx[2] = 12; b_mode[2] = 1; b_zero[2] = 1;
    b_idx[3] = 4;  b_mode[3] = 3; b_zero[3] = 0;
    run_burst("t3", 4);

    // 4: backpressure with A, B, C
    out_ready = 1'b0;
    in_valid = 1'b1; in_index = 5'd9; in_mode = 2'd0; in_zero = 1'b0;
    #1;
    check("t4 accept A", 64'(in_ready), 64'd1);
    next_cycle();
    in_index = 5'd3; in_mode = 2'd1;
    #1;
    check("t4 accept B", 64'(in_ready), 64'd1);
    next_cycle();
    in_index = 5'd15; in_mode = 2'd2;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("t4 full in_ready", 64'(in_ready), 64'd0);
      check("t4 stall valid", 64'(out_valid), 64'd1);
      check("t4 stall data A", 64'(out_data), 64'h200);
      next_cycle();
    end
    out_ready = 1'b1;
    #1;
    check("t4 accept C", 64'(in_ready), 64'd1);
    check("t4 out A", 64'(out_data), 64'h200);
    next_cycle();
    in_valid = 1'b0;
    #1;
    check("t4 valid B", 64'(out_valid), 64'd1);
    check("t4 out B", 64'(out_data), 64'hF);
    next_cycle();
    #1;
    check("t4 valid C", 64'(out_valid), 64'd1);
    check("t4 out C", 64'(out_data), 64'hFFFF_0000);
    next_cycle();
    #1;
    check("t4 drained", 64'(out_valid), 64'd0);

    // 5: reset with two items in flight
    out_ready = 1'b0;
    in_valid = 1'b1; in_index = 5'd20; in_mode = 2'd0;
    next_cycle();
    in_index = 5'd21;
    next_cycle();
    in_valid = 1'b0;
    reset    = 1'b1;
    #1;
    check("t5 in_ready in reset", 64'(in_ready), 64'd0);
    next_cycle();
    #1;
    check("t5 out_valid after reset", 64'(out_valid), 64'd0);
    reset     = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("t5 no stale", 64'(out_valid), 64'd0);
      next_cycle();
    end
    in_valid = 1'b1; in_index = 5'd3; in_mode = 2'd0; in_zero = 1'b0;
    #1;
    check("t5 accept", 64'(in_ready), 64'd1);
    next_cycle();
    in_valid = 1'b0;
    #1;
    check("t5 early out_valid", 64'(out_valid), 64'd0);
    next_cycle();
    #1;
    check("t5 out_valid", 64'(out_valid), 64'd1);
    check("t5 out_data", 64'(out_data), 64'h8);
    next_cycle();

    // 6: randomised valid/ready over 1000 items
    sent = 0; recv = 0; cyc = 0;
    pend = 1'b0; prev_stall = 1'b0; prev_out = '0;
    p_idx = 0; p_mode = 0; p_zero = 1'b0;
    q.delete();
    while (recv < 1000 && cyc < 20000) begin
      if (!pend && sent < 1000 && $urandom_range(0, 3) != 0) begin
        pend   = 1'b1;
        p_idx  = int'($urandom_range(0, 31));
        p_mode = int'($urandom_range(0, 3));
        p_zero = ($urandom_range(0, 7) == 0);
      end
      in_valid = pend;
      if (pend) begin
        in_index = 5'(p_idx);
        in_mode  = 2'(p_mode);
        in_zero  = p_zero;
      end else begin
        in_index = 5'($urandom);
        in_mode  = 2'($urandom);
        in_zero  = 1'($urandom);
      end
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      check("t6 in_ready", 64'(in_ready), 64'((sent - recv) < 2 || out_ready));
      if (prev_stall) begin
        check("t6 stall valid", 64'(out_valid), 64'd1);
        check("t6 stall hold", 64'({out_data, out_index, out_err}), 64'(prev_out));
      end
      if (out_valid) check("t6 no spurious output", 64'(q.size() > 0), 64'd1);
      in_fire  = pend && in_ready;
      out_fire = out_valid && out_ready;
      if (out_fire && q.size() > 0) begin
        e = q.pop_front();
        check("t6 out_data", 64'(out_data), 64'(e.d));
        check("t6 out_index", 64'(out_index), 64'(e.i));
        check("t6 out_err", 64'(out_err), 64'(e.e));
        recv++;
      end
      prev_stall = out_valid && !out_ready;
      prev_out   = {out_data, out_index, out_err};
      if (in_fire) begin
        e.d = ref_data(p_idx, p_mode, p_zero);
        e.i = 5'(p_idx);
        e.e = (p_mode == 3);
        q.push_back(e);
        sent++;
        pend = 1'b0;
      end
      next_cycle();
      cyc++;
    end
    check("t6 all received", 64'(recv), 64'd1000);
    check("t6 queue empty", 64'(q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
